hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Drives the 2-bit select of the EX-stage 3:1 operand muxes (A and B) of the RV32 pipeline.
//  It also generates load-use stall and branch-flush controls.
//  It keeps its own EX/MEM/WB destination scoreboard, loaded from ID-stage decode each cycle.
//  Select encoding matches MUX3: 00=a (regfile), 01=b (WB result), 10=c (MEM/ALU result), 11 never driven.
// PARAMETERS
//  RA_W    5   register address width
//  CNT_W   32  width of stall/flush performance counters
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  id_valid       in   1      ID holds a real instruction
//  id_rs1/id_rs2  in   RA_W   ID source registers
//  id_rd          in   RA_W   ID destination register
//  id_reg_write   in   1      ID instruction writes rd
//  id_mem_read    in   1      ID instruction is a load
//  ex_branch_tkn  in   1      branch/jump resolved taken in EX this cycle
//  fwd_a_sel      out  2      operand A select for the instruction now in EX (registered)
//  fwd_b_sel      out  2      operand B select (registered)
//  stall_if       out  1      hold PC (combinational)
//  stall_id       out  1      hold IF/ID register (combinational)
//  flush_id       out  1      squash IF/ID register (combinational)
//  flush_ex       out  1      insert bubble into ID/EX (combinational)
//  stall_cnt      out  CNT_W  load-use stall cycles since reset
//  flush_cnt      out  CNT_W  taken-branch flushes since reset
// BEHAVIOUR
//  Scoreboard: ex_{rd,wr,ld,v}, mem_{rd,wr,v}, wb_{rd,wr,v}; shifts ID->EX->MEM->WB every edge.
//   ID->EX shift loads a bubble (v=0) when flush_ex=1.
//  Load-use hazard: lu = id_valid & ex_v & ex_ld & ex_wr & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  stall_if = stall_id = lu & ~ex_branch_tkn; flush_ex = lu | ex_branch_tkn; flush_id = ex_branch_tkn.
//  Forward select, computed per source rs from ID inputs, registered at the edge (valid when consumer is in EX):
//   rs==0                                        -> 00
//   ex_v & ex_wr & ex_rd==rs & ~ex_ld            -> 10 (producer will be in MEM)
//   else mem_v & mem_wr & mem_rd==rs             -> 01 (producer will be in WB)
//   else                                         -> 00
//   Nearer producer wins. Loads never select 10; the load-use stall guarantees 01 on the retry.
//   When the select registers capture a bubble (flush_ex or ~id_valid), they load 00.
//  FSM (state register, 2 bits):
//   RUN:   lu & ~tkn -> STALL; tkn -> FLUSH; else RUN.
//   STALL: exactly one cycle, since the bubble clears ex_ld. tkn -> FLUSH, else RUN.
//   FLUSH: one cycle; id_valid is ignored (treated 0) -> RUN. A tkn seen here stays in FLUSH.
//  Counters: stall_cnt += 1 each cycle stall_if=1; flush_cnt += 1 each cycle ex_branch_tkn=1.
//   Both saturate at all-ones, no wrap.
//  Simultaneous lu & branch: the branch wins; no stall, both flushes asserted.
//  WB-stage writes are not forwarded; the register file is write-first, so wb_* only ages out.
//  Reset: all scoreboard v=0, fwd_*_sel=00, FSM=RUN, counters=0.
//   Combinational outputs are therefore 0 with inputs idle.
//   rst mid-STALL/FLUSH returns to RUN the next cycle with no residual stall.
// STRUCTURE
//  Shared package/header rv_pipe_defs: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, RA_W, FSM state encodings.
//  Sub-module fwd_sel_cmp: one instance per source operand (pure compare/priority).
//   It is instanced twice, for A and B. The scoreboard, FSM and counters live in the top.
// TESTING
//  1. ADD x5 then ADD x6,x5,x1 back-to-back -> next cycle fwd_a_sel=10, no stall.
//  2. ADD x5, NOP, SUB x7,x1,x5 -> fwd_b_sel=01. With rd=x0 in the producer -> sel 00.
//  3. LW x5 then ADD x6,x5,x5 -> stall_if=stall_id=flush_ex=1 for one cycle.
//     Then fwd_a_sel=fwd_b_sel=01, stall_cnt=1.
//  4. Both producers write x5 (EX and MEM) -> sel 10 (nearest wins).
//  5. ex_branch_tkn during a load-use -> flush_id=flush_ex=1, stall_if=0, FSM FLUSH, flush_cnt=1, stall_cnt=0.
//  6. Assert rst during STALL -> next cycle all outputs 0, counters 0. Saturation: preload count -> holds all-ones.

Source files
------------

// File: rtl/rv_pipe_defs_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_defs
// Shared definitions for the RV32 pipeline hazard/forwarding logic.
//   RA_W      : register address width
//   FWD_REG   : EX operand mux select, register file value
//   FWD_WB    : EX operand mux select, value now in WB (older producer)
//   FWD_MEM   : EX operand mux select, ALU result now in MEM (nearest producer)
//   hz_state_t: hazard controller state (RUN / STALL / FLUSH)
// ---------------------------------------------------------------------------
package rv_pipe_defs;

   localparam int RA_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } hz_state_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// ---------------------------------------------------------------------------
// fwd_sel_cmp
// Operand forwarding priority compare for one source register. Purely
// combinational; the caller registers the result.
// Ports:
//   rs            in  source register of the instruction in ID
//   ex_v/ex_wr/ex_ld/ex_rd    in  scoreboard entry of the instruction in EX
//   mem_v/mem_wr/mem_rd       in  scoreboard entry of the instruction in MEM
//   sel           out forward select the consumer will need once it is in EX
// ---------------------------------------------------------------------------
module fwd_sel_cmp #(
   parameter int RA_W = rv_pipe_defs::RA_W
) (
   input  logic [RA_W-1:0] rs,
   input  logic            ex_v,
   input  logic            ex_wr,
   input  logic            ex_ld,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            mem_v,
   input  logic            mem_wr,
   input  logic [RA_W-1:0] mem_rd,
   output logic [1:0]      sel
);

   import rv_pipe_defs::*;

   // The EX producer is one stage ahead of the consumer, so it will sit in MEM
   // when the consumer reaches EX; the MEM producer will sit in WB. The nearer
   // producer wins. A load in EX has no data yet, so it is never selected
   // here; the load-use stall delays the consumer until the load is in WB.
   always_comb begin
      sel = FWD_REG;
      if (rs != '0) begin
         if (ex_v && ex_wr && !ex_ld && (ex_rd == rs)) begin
            sel = FWD_MEM;
         end else if (mem_v && mem_wr && (mem_rd == rs)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
// Forwarding select generation plus load-use stall and taken-branch flush
// control for the RV32 pipeline. Tracks EX/MEM destinations itself, loaded
// from ID decode every cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1, id_rs2, id_rd     ID source / destination registers
//   id_reg_write, id_mem_read ID instruction writes rd / is a load
//   ex_branch_tkn             branch/jump resolved taken in EX this cycle
//   fwd_a_sel, fwd_b_sel      registered operand mux selects for EX
//   stall_if, stall_id        hold PC / hold IF/ID (combinational)
//   flush_id, flush_ex        squash IF/ID / bubble into ID/EX (combinational)
//   stall_cnt, flush_cnt      saturating stall-cycle and flush counters
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
   parameter int RA_W  = rv_pipe_defs::RA_W,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_branch_tkn,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import rv_pipe_defs::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   hz_state_t       state;
   hz_state_t       state_nxt;

   // WB results reach operands through the write-first register file, so only
   // the EX and MEM entries ever influence a select and only those are kept.
   logic            ex_v;
   logic            ex_wr;
   logic            ex_ld;
   logic [RA_W-1:0] ex_rd;
   logic            mem_v;
   logic            mem_wr;
   logic [RA_W-1:0] mem_rd;

   logic            id_live;
   logic            lu;
   logic            bubble;
   logic [1:0]      a_sel_nxt;
   logic [1:0]      b_sel_nxt;

   // The instruction in ID during the cycle after a flush is a squashed one.
   assign id_live = id_valid && (state != ST_FLUSH);

   assign lu = id_live && ex_v && ex_ld && ex_wr && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   assign bubble = flush_ex || !id_live;

   // Pipeline controls and next state. A taken branch overrides a load-use
   // stall: the dependent instruction is being squashed anyway.
   always_comb begin
      state_nxt = ST_RUN;
      stall_if  = lu && !ex_branch_tkn;
      stall_id  = lu && !ex_branch_tkn;
      flush_id  = ex_branch_tkn;
      flush_ex  = lu || ex_branch_tkn;
      case (state)
         ST_RUN: begin
            if (ex_branch_tkn)  state_nxt = ST_FLUSH;
            else if (lu)        state_nxt = ST_STALL;
            else                state_nxt = ST_RUN;
         end
         ST_STALL: begin
            state_nxt = ex_branch_tkn ? ST_FLUSH : ST_RUN;
         end
         ST_FLUSH: begin
            state_nxt = ex_branch_tkn ? ST_FLUSH : ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Destination scoreboard, advancing one stage per cycle. A stall or flush
   // inserts a bubble into EX.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v   <= 1'b0;
         ex_wr  <= 1'b0;
         ex_ld  <= 1'b0;
         ex_rd  <= '0;
         mem_v  <= 1'b0;
         mem_wr <= 1'b0;
         mem_rd <= '0;
      end else begin
         ex_v   <= id_live && !flush_ex;
         ex_wr  <= id_reg_write;
         ex_ld  <= id_mem_read;
         ex_rd  <= id_rd;
         mem_v  <= ex_v;
         mem_wr <= ex_wr;
         mem_rd <= ex_rd;
      end
   end

   fwd_sel_cmp #(.RA_W(RA_W)) u_sel_a (
      .rs     (id_rs1),
      .ex_v   (ex_v),
      .ex_wr  (ex_wr),
      .ex_ld  (ex_ld),
      .ex_rd  (ex_rd),
      .mem_v  (mem_v),
      .mem_wr (mem_wr),
      .mem_rd (mem_rd),
      .sel    (a_sel_nxt)
   );

   fwd_sel_cmp #(.RA_W(RA_W)) u_sel_b (
      .rs     (id_rs2),
      .ex_v   (ex_v),
      .ex_wr  (ex_wr),
      .ex_ld  (ex_ld),
      .ex_rd  (ex_rd),
      .mem_v  (mem_v),
      .mem_wr (mem_wr),
      .mem_rd (mem_rd),
      .sel    (b_sel_nxt)
   );

   // Selects travel with the instruction into EX; a bubble carries 00.
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         fwd_a_sel <= FWD_REG;
         fwd_b_sel <= FWD_REG;
      end else begin
         fwd_a_sel <= a_sel_nxt;
         fwd_b_sel <= b_sel_nxt;
      end
   end

   // Performance counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + 1'b1;
         if (ex_branch_tkn && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
// Directed vectors for hazard_forward_unit. Each vector drives the ID/EX
// inputs for one cycle and queues the outputs expected during that cycle;
// a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

   localparam int RA_W  = 5;
   localparam int CNT_W = 4;
   localparam int SAT   = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             id_valid = 1'b0;
   logic [RA_W-1:0]  id_rs1 = '0;
   logic [RA_W-1:0]  id_rs2 = '0;
   logic [RA_W-1:0]  id_rd = '0;
   logic             id_reg_write = 1'b0;
   logic             id_mem_read = 1'b0;
   logic             ex_branch_tkn = 1'b0;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             stall_if;
   logic             stall_id;
   logic             flush_id;
   logic             flush_ex;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   hazard_forward_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rd         (id_rd),
      .id_reg_write  (id_reg_write),
      .id_mem_read   (id_mem_read),
      .ex_branch_tkn (ex_branch_tkn),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .stall_if      (stall_if),
      .stall_id      (stall_id),
      .flush_id      (flush_id),
      .flush_ex      (flush_ex),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       stl;
      logic       fid;
      logic       fex;
      int         sc;
      int         fc;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic int sat(input int x);
      return (x > SAT) ? SAT : x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Drive one cycle of ID inputs and queue the outputs expected in that cycle.
   task automatic applyStimulus(input string name, input logic r, input logic v,
                                input int rs1, input int rs2, input int rd,
                                input logic wr, input logic ld, input logic tkn,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic stl, input logic fid, input logic fex,
                                input int sc, input int fc);
      exp_t e;
      @(posedge clk);
      #1;
      rst           = r;
      id_valid      = v;
      id_rs1        = RA_W'(rs1);
      id_rs2        = RA_W'(rs2);
      id_rd         = RA_W'(rd);
      id_reg_write  = wr;
      id_mem_read   = ld;
      ex_branch_tkn = tkn;
      e.name = name; e.fa = fa; e.fb = fb; e.stl = stl;
      e.fid = fid; e.fex = fex; e.sc = sc; e.fc = fc;
      expQ.push_back(e);
   endtask

   // Monitor: compare every queued expectation on the falling edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput({e.name, ".fwd_a_sel"}, 32'(fwd_a_sel), 32'(e.fa));
         checkOutput({e.name, ".fwd_b_sel"}, 32'(fwd_b_sel), 32'(e.fb));
         checkOutput({e.name, ".stall_if"},  32'(stall_if),  32'(e.stl));
         checkOutput({e.name, ".stall_id"},  32'(stall_id),  32'(e.stl));
         checkOutput({e.name, ".flush_id"},  32'(flush_id),  32'(e.fid));
         checkOutput({e.name, ".flush_ex"},  32'(flush_ex),  32'(e.fex));
         checkOutput({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
         checkOutput({e.name, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      //                 name       rst v  rs1 rs2 rd wr ld tk  fa fb stl fid fex sc fc
      applyStimulus("reset",      0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      // back-to-back ALU dependency
      applyStimulus("t1_add5",    0, 1,  1,  2, 5, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t1_add6",    0, 1,  5,  1, 6, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t1_chk",     0, 0,  0,  0, 0, 0, 0, 0,  2, 0, 0,  0,  0,  0, 0);
      // one instruction apart, then an x0 producer
      applyStimulus("t2_add5",    0, 1,  1,  2, 5, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t2_nop",     0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t2_sub7",    0, 1,  1,  5, 7, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t2_chk",     0, 0,  0,  0, 0, 0, 0, 0,  0, 1, 0,  0,  0,  0, 0);
      applyStimulus("t2_wrx0",    0, 1,  1,  2, 0, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t2_rdx0",    0, 1,  0,  3, 3, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t2_x0chk",   0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      // load-use stall
      applyStimulus("t3_lw5",     0, 1,  1,  0, 5, 1, 1, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t3_stall",   0, 1,  5,  5, 6, 1, 0, 0,  0, 0, 1,  0,  1,  0, 0);
      applyStimulus("t3_retry",   0, 1,  5,  5, 6, 1, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t3_chk",     0, 0,  0,  0, 0, 0, 0, 0,  1, 1, 0,  0,  0,  1, 0);
      // two producers of x5: nearest wins; a non-writing match is ignored
      applyStimulus("t4_add5a",   0, 1,  1,  2, 5, 1, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t4_add5b",   0, 1,  3,  4, 5, 1, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t4_use",     0, 1,  5,  5, 8, 1, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t4_chk",     0, 0,  0,  0, 0, 0, 0, 0,  2, 2, 0,  0,  0,  1, 0);
      applyStimulus("t4_nowr",    0, 1,  1,  2, 9, 0, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t4_use9",    0, 1,  9,  9,10, 1, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t4_nowrchk", 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 0);
      // branch taken during a load-use; squashed ID must not enter the scoreboard
      applyStimulus("t5_lw5",     0, 1,  1,  0, 5, 1, 1, 0,  0, 0, 0,  0,  0,  1, 0);
      applyStimulus("t5_lu_tkn",  0, 1,  5,  1, 6, 1, 0, 1,  0, 0, 0,  1,  1,  1, 0);
      applyStimulus("t5_flush",   0, 1,  5,  5, 7, 1, 0, 0,  0, 0, 0,  0,  0,  1, 1);
      applyStimulus("t5_use7",    0, 1,  7,  0, 8, 1, 0, 0,  0, 0, 0,  0,  0,  1, 1);
      applyStimulus("t5_gatechk", 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 1);
      applyStimulus("t5_tkn1",    0, 0,  0,  0, 0, 0, 0, 1,  0, 0, 0,  1,  1,  1, 1);
      applyStimulus("t5_tkn2",    0, 0,  0,  0, 0, 0, 0, 1,  0, 0, 0,  1,  1,  1, 2);
      applyStimulus("t5_sq11",    0, 1,  1,  2,11, 1, 0, 0,  0, 0, 0,  0,  0,  1, 3);
      applyStimulus("t5_use11",   0, 1, 11,  0,12, 1, 0, 0,  0, 0, 0,  0,  0,  1, 3);
      applyStimulus("t5_sqchk",   0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  1, 3);
      // reset while stalled
      applyStimulus("t6_lw5",     0, 1,  1,  0, 5, 1, 1, 0,  0, 0, 0,  0,  0,  1, 3);
      applyStimulus("t6_stall",   0, 1,  5,  2, 6, 1, 0, 0,  0, 0, 1,  0,  1,  1, 3);
      applyStimulus("t6_rst",     1, 1,  5,  2, 6, 1, 0, 0,  0, 0, 0,  0,  0,  2, 3);
      applyStimulus("t6_post",    0, 1,  5,  2, 6, 1, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      applyStimulus("t6_idle",    0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, 0);
      // flush counter saturation
      for (int i = 0; i < SAT + 1; i++)
         applyStimulus($sformatf("sat_tkn%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, sat(i));
      applyStimulus("sat_fend",   0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, SAT);
      applyStimulus("sat_fidle",  0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0,  0, SAT);
      // stall counter saturation: repeated load-use pairs
      for (int k = 0; k < SAT + 2; k++) begin
         applyStimulus($sformatf("sat_lw%0d", k),    0, 1, 1, 0, 5, 1, 1, 0,
                       (k == 0) ? 2'd0 : 2'd1, 2'd0, 0, 0, 0, sat(k), SAT);
         applyStimulus($sformatf("sat_stl%0d", k),   0, 1, 5, 0, 6, 1, 0, 0,
                       2'd0, 2'd0, 1, 0, 1, sat(k), SAT);
         applyStimulus($sformatf("sat_retry%0d", k), 0, 1, 5, 0, 6, 1, 0, 0,
                       2'd0, 2'd0, 0, 0, 0, sat(k + 1), SAT);
      end
      applyStimulus("sat_send",   0, 0,  0,  0, 0, 0, 0, 0,  1, 0, 0,  0,  0, SAT, SAT);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
      if (expQ.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending, required 0", expQ.size());
      end
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
